mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
Main control unit for the multicycle MIPS datapath. It sits directly upstream of the ALU and drives its 3-bit alucont code. It also drives every datapath mux select and write enable.
- Moore FSM sequences fetch/decode/execute/memory/writeback.
- Embedded ALU decoder maps op/funct to the ALU encoding: and=000, or=001, add=010, eq=100, slt=111.

Parameters:
OPW, 6, opcode/funct field width
STW, 4, state register width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
alueq  in  1  ALU result[0]; equals 1 when a==b under code 100
pcen  out  1  PC register enable
memwrite  out  1  data memory write
irwrite  out  1  instruction register load
regwrite  out  1  register file write
alusrca  out  1  0=PC, 1=regA
alusrcb  out  2  00=regB, 01=const 4, 10=signimm, 11=signimm<<2
iord  out  1  0=PC address, 1=ALUOut address
memtoreg  out  1  0=ALUOut, 1=MDR
regdst  out  1  0=rt, 1=rd
pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
alucontrol  out  3  to ALU alucont
illegal_op  out  1  one-cycle pulse on unsupported op/funct

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous, active-low, and sampled only on the rising edge of clk.
- While rst_n=0 at an edge, state<=FETCH.
- While rst_n=0, pcen, memwrite, irwrite, regwrite and illegal_op are forced to 0 combinationally. All other outputs take their FETCH values.
- Reset mid-instruction abandons the instruction; no partial write is issued after the reset edge.
- Outputs are Moore decodes of state, except:
  - pcen = pcwrite | (branch & alueq);
  - alucontrol in RTYPEEX depends on funct.
- Inactive defaults in every state: all enables 0, all selects 0, alucontrol=010.
- States and per-state outputs:
  - FETCH(0): iord=0, irwrite=1, alusrca=0, alusrcb=01, pcsrc=00, pcwrite=1 -> DECODE
  - DECODE(1): alusrca=0, alusrcb=11 (branch target into ALUOut). Next state by op:
    - 100011 lw or 101011 sw -> MEMADR
    - 000000 R-type -> RTYPEEX
    - 000100 beq -> BEQEX
    - 001000 addi -> ADDIEX
    - 000010 j -> JEX
    - any other op -> FETCH, with illegal_op=1 in this cycle
  - MEMADR(2): alusrca=1, alusrcb=10 -> MEMRD if lw, MEMWR if sw
  - MEMRD(3): iord=1 -> MEMWB
  - MEMWB(4): regdst=0, memtoreg=1, regwrite=1 -> FETCH
  - MEMWR(5): iord=1, memwrite=1 -> FETCH
  - RTYPEEX(6): alusrca=1, alusrcb=00. alucontrol by funct:
    - 100000 add -> 010
    - 100100 and -> 000
    - 100101 or -> 001
    - 101010 slt -> 111
    - other funct (including sub 100010; the ALU has no subtract) -> illegal_op=1, alucontrol=010, next state FETCH, no writeback
    - legal funct -> RTYPEWB
  - RTYPEWB(7): regdst=1, memtoreg=0, regwrite=1 -> FETCH
  - BEQEX(8): alusrca=1, alusrcb=00, alucontrol=100, pcsrc=01, branch=1 -> FETCH
  - ADDIEX(9): alusrca=1, alusrcb=10, alucontrol=010 -> ADDIWB
  - ADDIWB(10): regdst=0, memtoreg=0, regwrite=1 -> FETCH
  - JEX(11): pcsrc=10, pcwrite=1 -> FETCH
  - Encodings 12-15 are unreachable: outputs take defaults, next state FETCH.
- Cycle counts from FETCH to the next FETCH, inclusive: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal op 2.
- op and funct must be stable from DECODE until the instruction returns to FETCH; irwrite is asserted only in FETCH.
- illegal_op is never asserted in two consecutive cycles.

Decomposition:
- Shared package holds:
  - state encodings S_FETCH..S_JEX;
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J;
  - funct constants F_ADD, F_AND, F_OR, F_SLT;
  - ALU codes ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_EQ=100, ALU_SLT=111.
- One sub-module, mips_aludec: combinational; inputs aluop[1:0] and funct; outputs alucontrol and funct_bad. The FSM drives aluop: 00=add, 01=eq, 10=funct-decoded.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with op=100011 -> state FETCH; pcen=memwrite=irwrite=regwrite=0 during reset; first cycle after release shows irwrite=1, pcen=1, alusrcb=01.
- lw (op=100011): 5 cycles; MEMADR shows alucontrol=010, alusrcb=10; MEMWB shows regwrite=1, memtoreg=1; cycle 6 is FETCH.
- R-type slt (op=0, funct=101010): RTYPEEX alucontrol=111; RTYPEWB regwrite=1, regdst=1. Repeat with funct=100010 -> illegal_op=1 in RTYPEEX, no regwrite, FETCH next.
- beq, op=000100: alueq=1 -> BEQEX alucontrol=100, pcen=1, pcsrc=01. alueq=0 -> pcen=0; 3 cycles in both cases.
- j (op=000010) -> JEX pcsrc=10, pcen=1. Unknown op=111111 -> illegal_op=1 in DECODE, FETCH next, no write enables asserted.
- Reset mid-lw: rst_n=0 sampled in MEMRD -> next state FETCH, regwrite never asserted for that lw.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes, funct codes, ALU codes.
package mips_multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_EQ  = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] AOP_ADD   = 2'b00;
   localparam logic [1:0] AOP_EQ    = 2'b01;
   localparam logic [1:0] AOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_aludec.sv
// Combinational ALU decoder: aluop selects add, eq, or a funct-driven operation.
// funct_bad flags an R-type funct this ALU cannot execute.
module mips_aludec
   import mips_multicycle_ctrl_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic [1:0]     aluop,
   input  logic [OPW-1:0] funct,
   output logic [2:0]     alucontrol,
   output logic           funct_bad
);

   always_comb begin
      alucontrol = ALU_ADD;
      funct_bad  = 1'b0;
      case (aluop)
         AOP_EQ: alucontrol = ALU_EQ;
         AOP_FUNCT: begin
            case (funct)
               F_ADD:   alucontrol = ALU_ADD;
               F_AND:   alucontrol = ALU_AND;
               F_OR:    alucontrol = ALU_OR;
               F_SLT:   alucontrol = ALU_SLT;
               // sub and everything else: no subtractor in this ALU
               default: funct_bad = 1'b1;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: Moore FSM over fetch/decode/execute/memory/writeback
// driving datapath selects, write enables and the ALU control code.
module mips_multicycle_ctrl
   import mips_multicycle_ctrl_pkg::*;
#(
   parameter int OPW = 6,
   parameter int STW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] op,
   input  logic [OPW-1:0] funct,
   input  logic           alueq,
   output logic           pcen,
   output logic           memwrite,
   output logic           irwrite,
   output logic           regwrite,
   output logic           alusrca,
   output logic [1:0]     alusrcb,
   output logic           iord,
   output logic           memtoreg,
   output logic           regdst,
   output logic [1:0]     pcsrc,
   output logic [2:0]     alucontrol,
   output logic           illegal_op
);

   logic [STW-1:0] state;
   logic [STW-1:0] cur;
   logic [1:0]     aluop;
   logic           pcwrite;
   logic           branch;
   logic           funct_bad;
   logic           op_bad;
   logic           memwrite_s;
   logic           irwrite_s;
   logic           regwrite_s;

   mips_aludec #(.OPW(OPW)) u_aludec (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alucontrol),
      .funct_bad  (funct_bad)
   );

   assign op_bad = !(op == OP_LW || op == OP_SW || op == OP_RTYPE ||
                     op == OP_BEQ || op == OP_ADDI || op == OP_J);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: state <= S_MEMADR;
                  OP_RTYPE:     state <= S_RTYPEEX;
                  OP_BEQ:       state <= S_BEQEX;
                  OP_ADDI:      state <= S_ADDIEX;
                  OP_J:         state <= S_JEX;
                  default:      state <= S_FETCH;
               endcase
            end
            S_MEMADR:  state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state <= S_MEMWB;
            S_RTYPEEX: state <= funct_bad ? S_FETCH : S_RTYPEWB;
            S_ADDIEX:  state <= S_ADDIWB;
            default:   state <= S_FETCH;
         endcase
      end
   end

   // In reset the selects show FETCH values even before the first edge.
   assign cur = rst_n ? state : STW'(S_FETCH);

   always_comb begin
      pcwrite    = 1'b0;
      branch     = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      regwrite_s = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      pcsrc      = 2'b00;
      aluop      = AOP_ADD;
      illegal_op = 1'b0;
      case (cur)
         S_FETCH: begin
            irwrite_s = 1'b1;
            alusrcb   = 2'b01;
            pcwrite   = 1'b1;
         end
         S_DECODE: begin
            alusrcb    = 2'b11;
            illegal_op = op_bad;
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca    = 1'b1;
            aluop      = AOP_FUNCT;
            illegal_op = funct_bad;
         end
         S_RTYPEWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = AOP_EQ;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB: regwrite_s = 1'b1;
         S_JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
      if (!rst_n) illegal_op = 1'b0;
   end

   assign pcen     = rst_n & (pcwrite | (branch & alueq));
   assign memwrite = rst_n & memwrite_s;
   assign irwrite  = rst_n & irwrite_s;
   assign regwrite = rst_n & regwrite_s;

endmodule
